// File: rtl/simd_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module   : simd_issue_seq
//  Purpose  : Instruction issue sequencer for the SIMD core. Accepts packed
//             16-bit instruction words over a valid/ready handshake, registers
//             the decoded fields and issues at most one instruction per cycle.
//             New words are held off while the non-pipelined divider or a
//             load/store memory transaction is outstanding.
//  Ports    : clk, rst_n         clock, asynchronous active-low reset
//             instr_valid_i      instruction word valid
//             instr_ready_o      sequencer can accept a word this cycle
//             instr_i[15:0]      [15:11] opcode [10:9] funcode [8:7] dt
//                                [6] acc [5] sat [4:0] reserved
//             flush_i            synchronous abort of any outstanding wait
//             issue_valid_o      one-cycle issue pulse
//             opcode_o, funcode_o, dt_o, acc_o, sat_o   registered fields
//             div_busy_o         divider occupied
//             mem_req_o          load/store request, held until mem_ack_i
//             mem_ack_i          memory port completion
//             issue_count_o      issued-instruction counter (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module simd_issue_seq #(
    parameter int DIV_LAT = 8,   // divider occupancy in cycles, >= 2
    parameter int CNT_W   = 16   // issued-instruction counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [15:0]      instr_i,
    input  logic             flush_i,
    output logic             issue_valid_o,
    output logic [4:0]       opcode_o,
    output logic [1:0]       funcode_o,
    output logic [1:0]       dt_o,
    output logic             acc_o,
    output logic             sat_o,
    output logic             div_busy_o,
    output logic             mem_req_o,
    input  logic             mem_ack_i,
    output logic [CNT_W-1:0] issue_count_o
);

    localparam int DCNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

    // Unit class codes taken from opcode[4:2]
    localparam logic [2:0] CLS_DIV = 3'd2;
    localparam logic [2:0] CLS_MEM = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_DIV = 2'd1,
        S_WAIT_MEM = 2'd2
    } state_e;

    state_e             state_q;
    logic [DCNT_W-1:0]  div_cnt_q;
    logic               instr_ready_q;
    logic               issue_valid_q;
    logic [4:0]         opcode_q;
    logic [1:0]         funcode_q;
    logic [1:0]         dt_q;
    logic               acc_q;
    logic               sat_q;
    logic               div_busy_q;
    logic               mem_req_q;
    logic [CNT_W-1:0]   issue_count_q;

    logic               accept;
    logic [2:0]         unit_cls;
    logic               unused_reserved;

    assign accept          = instr_valid_i & instr_ready_q;
    assign unit_cls        = instr_i[15:13];
    assign unused_reserved = ^instr_i[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            instr_ready_q <= 1'b0;
            issue_valid_q <= 1'b0;
            opcode_q      <= '0;
            funcode_q     <= '0;
            dt_q          <= '0;
            acc_q         <= 1'b0;
            sat_q         <= 1'b0;
            div_busy_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            issue_count_q <= '0;
        end else begin
            issue_valid_q <= 1'b0;
            if (flush_i) begin
                // Abort everything outstanding; a word handed over this
                // cycle is dropped and never issued or counted.
                state_q       <= S_IDLE;
                div_cnt_q     <= '0;
                div_busy_q    <= 1'b0;
                mem_req_q     <= 1'b0;
                instr_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        instr_ready_q <= 1'b1;
                        if (accept) begin
                            opcode_q      <= instr_i[15:11];
                            funcode_q     <= instr_i[10:9];
                            dt_q          <= instr_i[8:7];
                            acc_q         <= instr_i[6];
                            sat_q         <= instr_i[5];
                            issue_valid_q <= 1'b1;
                            issue_count_q <= issue_count_q + 1'b1;
                            if (unit_cls == CLS_DIV) begin
                                // Busy spans the issue cycle plus DIV_LAT-1 more
                                state_q       <= S_WAIT_DIV;
                                div_cnt_q     <= DCNT_W'(DIV_LAT - 1);
                                div_busy_q    <= 1'b1;
                                instr_ready_q <= 1'b0;
                            end else if (unit_cls == CLS_MEM) begin
                                state_q       <= S_WAIT_MEM;
                                mem_req_q     <= 1'b1;
                                instr_ready_q <= 1'b0;
                            end
                        end
                    end
                    S_WAIT_DIV: begin
                        if (div_cnt_q == '0) begin
                            state_q       <= S_IDLE;
                            div_busy_q    <= 1'b0;
                            instr_ready_q <= 1'b1;
                        end else begin
                            div_cnt_q <= div_cnt_q - 1'b1;
                        end
                    end
                    S_WAIT_MEM: begin
                        if (mem_ack_i) begin
                            state_q       <= S_IDLE;
                            mem_req_q     <= 1'b0;
                            instr_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q       <= S_IDLE;
                        div_cnt_q     <= '0;
                        div_busy_q    <= 1'b0;
                        mem_req_q     <= 1'b0;
                        instr_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign instr_ready_o = instr_ready_q;
    assign issue_valid_o = issue_valid_q;
    assign opcode_o      = opcode_q;
    assign funcode_o     = funcode_q;
    assign dt_o          = dt_q;
    assign acc_o         = acc_q;
    assign sat_o         = sat_q;
    assign div_busy_o    = div_busy_q;
    assign mem_req_o     = mem_req_q;
    assign issue_count_o = issue_count_q;

endmodule
`default_nettype wire
